norm_unit: RTL and testbench
============================

NORM_UNIT -- requirements
Module: norm_unit

Interface
REQ-001 Parameters: none; data width is fixed at 32 and the shift-amount width at 5 through package constants.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 A  input  32  operand to normalize; sampled on the accepting edge only.
REQ-006 is_signed  input  1  0 = count leading zeros; 1 = count redundant sign bits; sampled with A.
REQ-007 busy  output  1  high from the accepting edge until the cycle done asserts, inclusive.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 result  output  32  normalized operand, i.e. A shifted left by shift_amount.
REQ-010 shift_amount  output  5  left-shift count that normalizes A; matches the shifter's shift-amount input format.
REQ-011 is_zero  output  1  operand was 0x00000000.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE, and SHALL enter IDLE at reset.
REQ-013 IDLE with start=1: load the working register with A, set the count to 0 and latch is_signed; go to DONE if A==0 (is_zero=1), else go to RUN.
REQ-014 IDLE with start=0: hold all outputs unchanged.
REQ-015 RUN: the value is normalized when bit31==1 (unsigned) or bit31!=bit30 (signed).
REQ-016 RUN, normalized or count==31: go to DONE without shifting.
REQ-017 RUN, otherwise: shift the working register left by 1, zero-fill bit 0, increment the count, and stay in RUN.
REQ-018 DONE: assert done for exactly one cycle, then go to IDLE.
REQ-019 result, shift_amount and is_zero SHALL be valid while done=1.
REQ-020 result, shift_amount and is_zero SHALL hold their values until the next accepted start.
REQ-021 Latency: done is high k+2 cycles after the start cycle for non-zero A with shift k, and 1 cycle after it for A==0.
REQ-022 start while busy SHALL be ignored; no queuing and no restart.
REQ-023 start in the DONE cycle SHALL be ignored.
REQ-024 Count cap: the count SHALL never exceed 31, so shift_amount cannot wrap.
REQ-025 For signed A=0xFFFFFFFF the unit SHALL stop at the cap with shift_amount=31 and result=0x80000000.
REQ-026 For zero A the outputs SHALL be result=0 and shift_amount=0, independent of is_signed.
REQ-027 A or is_signed changing while busy SHALL NOT affect the operation in progress.

Reset
REQ-028 While reset=1, regardless of clk: state=IDLE, busy=0, done=0, result=0, shift_amount=0, is_zero=0, working register=0, count=0.
REQ-029 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow.
REQ-030 start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-031 Shared package norm_pkg SHALL hold the state enum {IDLE, RUN, DONE}, DATA_W=32 and SHAMT_W=5.
REQ-032 One combinational sub-module, norm_detect, SHALL evaluate the normalized condition from the working register and the latched is_signed.
REQ-033 The FSM, working register and counter SHALL live in norm_unit.

Verification
REQ-034 Unsigned A=0x00010000 -> shift_amount=15, result=0x80000000, is_zero=0, done 17 cycles after start.
REQ-035 Signed A=0xFFFF0000 -> shift_amount=15, result=0x80000000; unsigned A=0x80000000 -> shift_amount=0, done 2 cycles after start.
REQ-036 A=0x00000000 in either mode -> is_zero=1, result=0, shift_amount=0, done 1 cycle after start.
REQ-037 Signed A=0xFFFFFFFF -> shift_amount=31, result=0x80000000, done 33 cycles after start.
REQ-038 start=1 with A=0x1 held every cycle during a run -> exactly one done pulse, outputs from the first operand.
REQ-039 reset pulsed mid-RUN -> busy=0 and all outputs 0 immediately, no done pulse, next start processed normally.

Source files
------------

// File: rtl/norm_pkg.sv
// ============================================================================
// Module : norm_pkg
// Desc   : Shared widths and FSM state encoding for the normalization unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package norm_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/norm_detect.sv
// ============================================================================
// Module : norm_detect
// Desc   : Flags when the working value is normalized (leading-one or sign).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module norm_detect
    import norm_pkg::*;
(
    input  logic [DATA_W-1:0] i_value,
    input  logic              i_signed,
    output logic              o_norm
);

    // Signed values are normalized once the top two bits differ.
    always_comb begin
        if (i_signed) begin
            o_norm = i_value[DATA_W-1] ^ i_value[DATA_W-2];
        end else begin
            o_norm = i_value[DATA_W-1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/norm_unit.sv
// ============================================================================
// Module : norm_unit
// Desc   : Iterative normalizer; shifts left one bit per cycle until normalized.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module norm_unit
    import norm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DATA_W-1:0]  A,
    input  logic               is_signed,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  result,
    output logic [SHAMT_W-1:0] shift_amount,
    output logic               is_zero
);

    localparam logic [SHAMT_W-1:0] c_CNT_MAX = '1;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_work;
    logic [SHAMT_W-1:0]  r_count;
    logic                r_signed;
    logic                r_zero;
    logic                w_norm;
    logic                w_at_cap;
    logic                w_a_zero;

    norm_detect u_detect (
        .i_value  (r_work),
        .i_signed (r_signed),
        .o_norm   (w_norm)
    );

    assign w_at_cap = (r_count == c_CNT_MAX);
    assign w_a_zero = (A == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = w_a_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_norm || w_at_cap) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == DONE);
    end

    // Working register and count hold outside of accept/shift, so they double as outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_work   <= '0;
            r_count  <= '0;
            r_signed <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_work   <= A;
                        r_count  <= '0;
                        r_signed <= is_signed;
                        r_zero   <= w_a_zero;
                    end
                end
                RUN: begin
                    if (!(w_norm || w_at_cap)) begin
                        r_work  <= {r_work[DATA_W-2:0], 1'b0};
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result       = r_work;
    assign shift_amount = r_count;
    assign is_zero      = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_norm_unit.sv
// ============================================================================
// Module : tb_norm_unit
// Desc   : Scoreboard bench for norm_unit with directed operands.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_norm_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic        is_signed;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  shift_amount;
    logic        is_zero;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  sh;
        logic        z;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    norm_unit dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .A            (A),
        .is_signed    (is_signed),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .shift_amount (shift_amount),
        .is_zero      (is_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_done: got done=1 at cycle %0d expected no pending operation", cyc);
            end else begin
                e = sb.pop_front();
                check("result",  result,       e.res);
                check("shamt",   shift_amount, e.sh);
                check("is_zero", is_zero,      e.z);
                check("latency", cyc,          e.t0 + e.lat);
                check("busy_at_done", busy,    1'b1);
            end
        end
    end

    // Caller must be at a negedge; start is held for one accepting edge.
    task automatic send(input logic [31:0] a, input logic s, input logic [31:0] r,
                        input logic [4:0] sh, input logic z, input int lat);
        exp_t e;
        start     = 1'b1;
        A         = a;
        is_signed = s;
        e.res = r; e.sh = sh; e.z = z; e.lat = lat; e.t0 = cyc;
        sb.push_back(e);
        @(negedge clk);
        start     = 1'b0;
        A         = $urandom;
        is_signed = ~s;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL timeout: got no done after %0d cycles expected done", bound);
            sb.delete();
        end
    endtask

    task automatic run(input logic [31:0] a, input logic s, input logic [31:0] r,
                       input logic [4:0] sh, input logic z, input int lat);
        send(a, s, r, sh, z, lat);
        wait_done(60);
        repeat (2) @(negedge clk);
        check("hold_result", {result, shift_amount, is_zero}, {r, sh, z});
        check("idle_busy", {busy, done}, 2'b00);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        A         = 32'hDEAD_BEEF;
        is_signed = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {busy, done, result, shift_amount, is_zero}, 40'd0);
        reset = 1'b0;

        run(32'h0001_0000, 1'b0, 32'h8000_0000, 5'd15, 1'b0, 17);
        run(32'hFFFF_0000, 1'b1, 32'h8000_0000, 5'd15, 1'b0, 17);
        run(32'h8000_0000, 1'b0, 32'h8000_0000, 5'd0,  1'b0, 2);
        run(32'h0000_0000, 1'b0, 32'h0000_0000, 5'd0,  1'b1, 1);
        run(32'h0000_0000, 1'b1, 32'h0000_0000, 5'd0,  1'b1, 1);
        run(32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 5'd31, 1'b0, 33);
        run(32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0, 33);
        run(32'h0000_0001, 1'b1, 32'h4000_0000, 5'd30, 1'b0, 32);
        run(32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 5'd0,  1'b0, 2);
        run(32'hC000_0000, 1'b1, 32'h8000_0000, 5'd1,  1'b0, 3);
        run(32'h00F0_0000, 1'b0, 32'hF000_0000, 5'd8,  1'b0, 10);

        // start held high with a new operand for the whole run
        begin
            exp_t e;
            start = 1'b1; A = 32'h0001_0000; is_signed = 1'b0;
            e.res = 32'h8000_0000; e.sh = 5'd15; e.z = 1'b0; e.lat = 17; e.t0 = cyc;
            sb.push_back(e);
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done) break;
                A = 32'h0000_0001;
            end
            start = 1'b0;
            repeat (5) @(negedge clk);
            check("no_restart", {busy, sb.size() == 0}, 2'b01);
            sb.delete();
        end

        // reset mid-run aborts without a done pulse
        send(32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0, 33);
        repeat (5) @(negedge clk);
        check("busy_before_reset", busy, 1'b1);
        #2 reset = 1'b1;
        #1 check("async_reset", {busy, done, result, shift_amount, is_zero}, 40'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("idle_after_abort", {busy, done}, 2'b00);
        run(32'h0000_0300, 1'b0, 32'hC000_0000, 5'd22, 1'b0, 24);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
